// File: rtl/axis_stream_checker_if.sv
// AXI-Stream beat bundle between an upstream master and the stream checker.
// Carries only the handshake and payload; clock and reset stay with the modules.
interface axis_stream_checker_if #(
  parameter int WIDTH = 32
) ();
  logic               tvalid;
  logic               tready;
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tstrb;
  logic               tlast;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing data sequence, full strobes and
// frame length under a pseudo-random backpressure pattern, with saturating counters.
module axis_stream_checker #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 32
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  axis_stream_checker_if.slave  s00_axis,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_throttle,
  input  logic                  cfg_clear,
  output logic                  locked,
  output logic [CNT_W-1:0]      beat_count,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      seq_err_count,
  output logic [CNT_W-1:0]      len_err_count,
  output logic [CNT_W-1:0]      strb_err_count,
  output logic                  err_pulse
);

  typedef enum logic [1:0] {IDLE, HUNT, LOCK} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t           state;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] expected;
  logic [15:0]      beat_idx;
  logic             pattern;
  logic             accept;
  logic             len_bad;
  logic             vld_p0;
  logic             last_p0;
  logic             seq_bad_p0;
  logic             len_bad_p0;
  logic             strb_bad_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    pattern = 1'b1;
    case (cfg_throttle)
      2'd0: pattern = 1'b1;
      2'd1: pattern = (lfsr[1:0] != 2'b00);
      2'd2: pattern = lfsr[0];
      2'd3: pattern = (lfsr[1:0] == 2'b00);
      default: pattern = 1'b1;
    endcase
  end

  assign accept  = s00_axis.tvalid & s00_axis.tready;
  assign len_bad = s00_axis.tlast ? (beat_idx != LAST_IDX) : (beat_idx == LAST_IDX);

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state           <= IDLE;
      lfsr            <= 16'hACE1;
      s00_axis.tready <= 1'b0;
      expected        <= '0;
      beat_idx        <= '0;
      locked          <= 1'b0;
      vld_p0          <= 1'b0;
      last_p0         <= 1'b0;
      seq_bad_p0      <= 1'b0;
      len_bad_p0      <= 1'b0;
      strb_bad_p0     <= 1'b0;
      beat_count      <= '0;
      frame_count     <= '0;
      seq_err_count   <= '0;
      len_err_count   <= '0;
      strb_err_count  <= '0;
      err_pulse       <= 1'b0;
    end else begin
      // stage 0: handshake, sequence/length tracking, error flags for the accepted beat
      if (cfg_enable) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      s00_axis.tready <= (state != IDLE) & cfg_enable & pattern;

      vld_p0      <= accept & ~cfg_clear;
      last_p0     <= s00_axis.tlast;
      seq_bad_p0  <= (state == LOCK) && (s00_axis.tdata != expected);
      len_bad_p0  <= len_bad;
      strb_bad_p0 <= (s00_axis.tstrb != '1);

      // A mismatch resynchronises, so the next expected value is always tdata+1.
      if (accept) begin
        expected <= s00_axis.tdata + 1'b1;
        beat_idx <= (len_bad || beat_idx == LAST_IDX) ? 16'd0 : beat_idx + 16'd1;
        locked   <= 1'b1;
      end

      if (!cfg_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= locked ? LOCK : HUNT;
          HUNT:    if (accept) state <= LOCK;
          LOCK:    state <= LOCK;
          default: state <= IDLE;
        endcase
      end

      // stage 1: counters and error pulse, one cycle after acceptance
      beat_count     <= sat_inc(beat_count, vld_p0);
      frame_count    <= sat_inc(frame_count, vld_p0 & last_p0);
      seq_err_count  <= sat_inc(seq_err_count, vld_p0 & seq_bad_p0);
      len_err_count  <= sat_inc(len_err_count, vld_p0 & len_bad_p0);
      strb_err_count <= sat_inc(strb_err_count, vld_p0 & strb_bad_p0);
      err_pulse      <= vld_p0 & (seq_bad_p0 | len_bad_p0 | strb_bad_p0);

      if (cfg_clear) begin
        state          <= cfg_enable ? HUNT : IDLE;
        beat_idx       <= '0;
        locked         <= 1'b0;
        beat_count     <= '0;
        frame_count    <= '0;
        seq_err_count  <= '0;
        len_err_count  <= '0;
        strb_err_count <= '0;
        err_pulse      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: table of stream segments with
// hand-computed counter totals, plus hand sequences for pause, clear and reset.
module tb_axis_stream_checker;

  localparam int FL = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_throttle = 2'd0;
  logic        cfg_clear = 1'b0;
  logic        locked;
  logic [31:0] beat_count, frame_count, seq_err_count, len_err_count, strb_err_count;
  logic        err_pulse;

  axis_stream_checker_if #(.WIDTH(32)) bus ();

  axis_stream_checker #(.WIDTH(32), .FRAME_LEN(FL), .CNT_W(32)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (bus),
    .cfg_enable       (cfg_enable),
    .cfg_throttle     (cfg_throttle),
    .cfg_clear        (cfg_clear),
    .locked           (locked),
    .beat_count       (beat_count),
    .frame_count      (frame_count),
    .seq_err_count    (seq_err_count),
    .len_err_count    (len_err_count),
    .strb_err_count   (strb_err_count),
    .err_pulse        (err_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int meas_cyc = 0;
  int meas_hi = 0;
  logic meas = 1'b0;

  always @(negedge clk) begin
    if (err_pulse) pulses <= pulses + 1;
    if (meas) begin
      meas_cyc <= meas_cyc + 1;
      if (bus.tready) meas_hi <= meas_hi + 1;
    end
  end

  typedef struct {
    string       name;
    logic [1:0]  thr;
    logic [31:0] start;
    int          nbeats;
    int          skip_at;
    int          last_at;
    int          strb_at;
    int          e_beat;
    int          e_frame;
    int          e_seq;
    int          e_len;
    int          e_strb;
    int          e_pulse;
  } seg_t;

  seg_t segs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    n = 0;
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tstrb  = s;
    bus.tlast  = l;
    forever begin
      @(negedge clk);
      if (bus.tready) break;
      n++;
      if (n > 2000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: tready low for %0d cycles, required a handshake", n);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.tvalid = 1'b0;
    @(posedge clk); #1;
    cfg_clear = 1'b1;
    @(posedge clk); #1;
    cfg_clear = 1'b0;
  endtask

  // Sends n clean beats from d, tlast on the frame boundary tracked by pos.
  task automatic stream(input int n, inout logic [31:0] d, inout int pos);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = (pos == FL - 1);
      send_beat(d, 4'hF, l);
      pos = l ? 0 : pos + 1;
      d = d + 1;
    end
  endtask

  task automatic settle();
    bus.tvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int pos, p0, mc0, mh0, cyc, hi, duty;
    logic lst;

    segs[0] = '{"thr0_stream", 2'd0, 32'h1000, 4096, -1, -1, -1, 4096, 4, 0, 0, 0, 0};
    segs[1] = '{"thr3_stream", 2'd3, 32'h1000, 4096, -1, -1, -1, 4096, 4, 0, 0, 0, 0};
    segs[2] = '{"seq_skip",    2'd0, 32'h1000, 1024,  5, -1, -1, 1024, 1, 1, 0, 0, 1};
    segs[3] = '{"early_last",  2'd0, 32'h1000, 2025, -1, 1000, -1, 2025, 2, 0, 1, 0, 1};
    segs[4] = '{"wrap_strb",   2'd1, 32'hFFFFFFFE, 8, -1, -1, 2, 8, 0, 0, 0, 1, 1};
    segs[5] = '{"multi_err",   2'd2, 32'h0, 10, 3, 3, 3, 10, 1, 1, 1, 1, 1};

    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    bus.tstrb  = 4'hF;
    bus.tlast  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_tready", bus.tready, 0);
    check("rst_locked", locked, 0);
    check("rst_beat", beat_count, 0);
    check("rst_frame", frame_count, 0);
    check("rst_seq", seq_err_count, 0);
    check("rst_len", len_err_count, 0);
    check("rst_strb", strb_err_count, 0);
    check("rst_pulse", err_pulse, 0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 6; s++) begin
      do_clear();
      cfg_throttle = segs[s].thr;
      p0 = pulses;
      d = segs[s].start;
      pos = 0;
      mc0 = 0;
      mh0 = 0;
      for (int i = 0; i < segs[s].nbeats; i++) begin
        if (i == segs[s].skip_at) d = d + 1;
        lst = (i == segs[s].last_at) || (pos == FL - 1);
        send_beat(d, (i == segs[s].strb_at) ? 4'h7 : 4'hF, lst);
        pos = lst ? 0 : pos + 1;
        d = d + 1;
        if (i == 0) begin
          mc0 = meas_cyc;
          mh0 = meas_hi;
          meas = 1'b1;
        end
      end
      meas = 1'b0;
      settle();
      check({segs[s].name, "_beat"}, beat_count, segs[s].e_beat);
      check({segs[s].name, "_frame"}, frame_count, segs[s].e_frame);
      check({segs[s].name, "_seq"}, seq_err_count, segs[s].e_seq);
      check({segs[s].name, "_len"}, len_err_count, segs[s].e_len);
      check({segs[s].name, "_strb"}, strb_err_count, segs[s].e_strb);
      check({segs[s].name, "_pulses"}, pulses - p0, segs[s].e_pulse);
      check({segs[s].name, "_locked"}, locked, 1);
      cyc = meas_cyc - mc0;
      hi  = meas_hi - mh0;
      if (segs[s].thr == 2'd0) check({segs[s].name, "_tready_low"}, cyc - hi, 0);
      if (segs[s].thr == 2'd3) begin
        duty = (cyc > 0) ? (hi * 100) / cyc : 0;
        tests++;
        if (duty < 20 || duty > 30) begin
          fails++;
          $display("FAIL thr3_duty: got %0d%% required 20..30%%", duty);
        end
      end
    end

    // Pause mid-frame, then resume: first beat after re-enable is checked in LOCK.
    do_clear();
    cfg_throttle = 2'd0;
    d = 32'h2000;
    pos = 0;
    stream(500, d, pos);
    bus.tvalid = 1'b0;
    cfg_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_tready", bus.tready, 0);
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tready) hi++;
    end
    check("dis_tready_50", hi, 0);
    check("dis_hold_beat", beat_count, 500);
    cfg_enable = 1'b1;
    send_beat(d + 32'd10, 4'hF, 1'b0);
    d = d + 32'd11;
    pos = pos + 1;
    stream(FL - pos, d, pos);
    settle();
    check("resume_seq", seq_err_count, 1);
    check("resume_beat", beat_count, 1024);
    check("resume_frame", frame_count, 1);
    check("resume_len", len_err_count, 0);

    // Clear coinciding with an accepted beat: that beat is dropped, HUNT re-seeds.
    do_clear();
    d = 32'h3000;
    pos = 0;
    stream(20, d, pos);
    cfg_clear = 1'b1;
    send_beat(32'h7777, 4'hF, 1'b0);
    cfg_clear = 1'b0;
    d = 32'h9000;
    pos = 0;
    stream(FL, d, pos);
    settle();
    check("clr_beat", beat_count, 1024);
    check("clr_frame", frame_count, 1);
    check("clr_seq", seq_err_count, 0);
    check("clr_len", len_err_count, 0);

    // Asynchronous reset mid-frame, then a fresh stream re-seeds without errors.
    do_clear();
    d = 32'h4000;
    pos = 0;
    stream(300, d, pos);
    bus.tdata = d;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tready", bus.tready, 0);
    bus.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_beat", beat_count, 0);
    check("arst_locked", locked, 0);
    rst_n = 1'b1;
    p0 = pulses;
    d = 32'h5555;
    pos = 0;
    stream(FL, d, pos);
    settle();
    check("reseed_beat", beat_count, 1024);
    check("reseed_frame", frame_count, 1);
    check("reseed_errs", seq_err_count + len_err_count + strb_err_count, 0);
    check("reseed_pulses", pulses - p0, 0);
    check("reseed_locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
